// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: fixed-latency pipelined multiplier and an iterative
// radix-2 restoring divider with early-out special cases, one operation at a time.
module muldiv_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MUL, DIV_ITER, DIV_FIX, DONE} fsmState;

  fsmState stateQ, stateNext;

  logic            accept;
  logic            aSgn, bSgn;
  logic [PW-1:0]   aExt, bExt, mulIn, finalProd;
  logic            divSigned, aNeg, bNeg, divZero, divOvf;
  logic [XLEN-1:0] absA, absB;

  logic [1:0]      opQ;
  logic [XLEN-1:0] aQ, divisorQ, quotQ, remQ;
  logic            qNegQ, rNegQ, zeroQ, ovfQ;
  logic [CNT_W-1:0] cntQ;

  logic [XLEN:0]   shifted, diff;
  logic            trialOk;
  logic [XLEN-1:0] quotFix, remFix, divResult, resultNext;

  assign accept = (stateQ == IDLE) && start_i && !flush_i;

  // Operand extension: MULH signed x signed, MULHSU signed x unsigned, else unsigned
  assign aSgn  = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
  assign bSgn  = (funct3_i[1:0] == 2'b01);
  assign aExt  = {{XLEN{aSgn & a_i[XLEN-1]}}, a_i};
  assign bExt  = {{XLEN{bSgn & b_i[XLEN-1]}}, b_i};
  assign mulIn = aExt * bExt;

  // result_o is the last multiply stage, so only MUL_STAGES-1 pipeline registers sit before it
  if (MUL_STAGES == 1) begin : gDirect
    assign finalProd = mulIn;
  end else begin : gPipe
    logic [PW-1:0] pipe [MUL_STAGES-1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(MUL_STAGES) - 1; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= mulIn;
        for (int i = 1; i < int'(MUL_STAGES) - 1; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign finalProd = pipe[MUL_STAGES-2];
  end

  function automatic logic [XLEN-1:0] selMul(input logic [PW-1:0] p, input logic [1:0] f);
    return (f == 2'b00) ? p[XLEN-1:0] : p[PW-1:XLEN];
  endfunction

  // Divide setup values, captured on the accepting edge
  assign divSigned = ~funct3_i[0];
  assign aNeg      = divSigned & a_i[XLEN-1];
  assign bNeg      = divSigned & b_i[XLEN-1];
  assign absA      = aNeg ? -a_i : a_i;
  assign absB      = bNeg ? -b_i : b_i;
  assign divZero   = (b_i == '0);
  assign divOvf    = divSigned && (a_i == MIN_NEG) && (b_i == '1);

  // One restoring step: quotient bits shift in from the bottom as dividend bits leave the top
  assign shifted = {remQ, quotQ[XLEN-1]};
  assign diff    = shifted - {1'b0, divisorQ};
  assign trialOk = ~diff[XLEN];

  always_comb begin
    quotFix    = qNegQ ? -quotQ : quotQ;
    remFix     = rNegQ ? -remQ : remQ;
    divResult  = opQ[1] ? remFix : quotFix;
    if (zeroQ)     divResult = opQ[1] ? aQ : '1;
    else if (ovfQ) divResult = opQ[1] ? '0 : aQ;
    case (stateQ)
      IDLE:    resultNext = selMul(mulIn, funct3_i[1:0]);
      MUL:     resultNext = selMul(finalProd, opQ);
      default: resultNext = divResult;
    endcase
  end

  always_comb begin
    stateNext = stateQ;
    if (flush_i) begin
      stateNext = IDLE;
    end else begin
      case (stateQ)
        IDLE: begin
          if (start_i) begin
            if (!funct3_i[2]) stateNext = (MUL_STAGES == 1) ? DONE : MUL;
            else              stateNext = (divZero || divOvf) ? DIV_FIX : DIV_ITER;
          end
        end
        MUL:      if (cntQ == CNT_W'(MUL_STAGES - 2)) stateNext = DONE;
        DIV_ITER: if (cntQ == CNT_W'(XLEN - 1)) stateNext = DIV_FIX;
        DIV_FIX:  stateNext = DONE;
        DONE:     stateNext = IDLE;
        default:  stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stateQ <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      stateQ <= stateNext;
      busy_o <= (stateNext == MUL) || (stateNext == DIV_ITER) || (stateNext == DIV_FIX);
      done_o <= (stateNext == DONE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opQ      <= '0;
      aQ       <= '0;
      divisorQ <= '0;
      quotQ    <= '0;
      remQ     <= '0;
      qNegQ    <= 1'b0;
      rNegQ    <= 1'b0;
      zeroQ    <= 1'b0;
      ovfQ     <= 1'b0;
      cntQ     <= '0;
      result_o <= '0;
    end else begin
      if (accept) begin
        opQ      <= funct3_i[1:0];
        aQ       <= a_i;
        divisorQ <= absB;
        quotQ    <= absA;
        remQ     <= '0;
        qNegQ    <= aNeg ^ bNeg;
        rNegQ    <= aNeg;
        zeroQ    <= divZero;
        ovfQ     <= divOvf;
        cntQ     <= '0;
      end else if (stateQ == DIV_ITER) begin
        remQ  <= trialOk ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quotQ <= {quotQ[XLEN-2:0], trialOk};
        cntQ  <= cntQ + CNT_W'(1);
      end else if (stateQ == MUL) begin
        cntQ <= cntQ + CNT_W'(1);
      end
      if (stateNext == DONE) result_o <= resultNext;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: three instances (32/2, 8/1, 8/4) driven with
// directed and random operations, checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int NDUT = 3;
  localparam int XL [NDUT] = '{32, 8, 8};
  localparam int MS [NDUT] = '{2, 1, 4};

  typedef struct {
    int          idx;
    logic [31:0] res;
    int          doneCyc;
  } expT;

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } dirT;

  localparam int NDIR = 12;
  localparam dirT DIRS [NDIR] = '{
    '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE},
    '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
    '{3'b110, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E},
    '{3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002}
  };

  logic clk = 1'b0;
  logic rst_n;
  logic        startS [NDUT];
  logic        flushS [NDUT];
  logic [2:0]  f3S    [NDUT];
  logic [31:0] aS     [NDUT];
  logic [31:0] bS     [NDUT];

  logic        busy0, busy1, busy2, done0, done1, done2;
  logic [31:0] res0;
  logic [7:0]  res1, res2;
  logic        busyW [NDUT];
  logic        doneW [NDUT];
  logic [31:0] resW  [NDUT];

  assign busyW[0] = busy0;
  assign busyW[1] = busy1;
  assign busyW[2] = busy2;
  assign doneW[0] = done0;
  assign doneW[1] = done1;
  assign doneW[2] = done2;
  assign resW[0]  = res0;
  assign resW[1]  = {24'd0, res1};
  assign resW[2]  = {24'd0, res2};

  muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startS[0]), .funct3_i(f3S[0]),
    .a_i(aS[0]), .b_i(bS[0]), .flush_i(flushS[0]),
    .busy_o(busy0), .done_o(done0), .result_o(res0));

  muldiv_unit #(.XLEN(8), .MUL_STAGES(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startS[1]), .funct3_i(f3S[1]),
    .a_i(aS[1][7:0]), .b_i(bS[1][7:0]), .flush_i(flushS[1]),
    .busy_o(busy1), .done_o(done1), .result_o(res1));

  muldiv_unit #(.XLEN(8), .MUL_STAGES(4)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(startS[2]), .funct3_i(f3S[2]),
    .a_i(aS[2][7:0]), .b_i(bS[2][7:0]), .flush_i(flushS[2]),
    .busy_o(busy2), .done_o(done2), .result_o(res2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  expT         sbq [$];
  int          bStart  [NDUT];
  int          bEnd    [NDUT];
  logic [31:0] lastRes [NDUT];
  int          checks = 0;
  int          passes = 0;

  function automatic void check(input string name, input int i, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", name, i, cyc, act, exp);
  endfunction

  function automatic logic [31:0] mask(input int xlen);
    return (xlen >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << xlen) - 64'd1);
  endfunction

  // Reference: RV32M semantics in plain wide arithmetic
  function automatic logic [31:0] refModel(input int xlen, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b);
    longint half, sa, sb, r;
    logic [63:0] ua, ub, up;
    half = longint'(1) << (xlen - 1);
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'(ua);
    sb = longint'(ub);
    if (sa >= half) sa = sa - 2 * half;
    if (sb >= half) sb = sb - 2 * half;
    case (f3)
      3'b000:  r = sa * sb;
      3'b001:  r = (sa * sb) >>> xlen;
      3'b010:  r = (sa * longint'(ub)) >>> xlen;
      3'b011:  begin up = ua * ub; r = longint'(up >> xlen); end
      3'b100:  r = (ub == 0) ? -1 : (sa == -half && sb == -1) ? sa : sa / sb;
      3'b101:  r = (ub == 0) ? -1 : longint'(ua / ub);
      3'b110:  r = (ub == 0) ? sa : (sa == -half && sb == -1) ? 0 : sa % sb;
      default: r = (ub == 0) ? longint'(ua) : longint'(ua % ub);
    endcase
    return 32'(r) & mask(xlen);
  endfunction

  function automatic int latency(input int i, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] minNeg;
    minNeg = 32'(1) << (XL[i] - 1);
    if (!f3[2]) return MS[i];
    if (b == 32'd0) return 2;
    if (!f3[0] && a == minNeg && b == mask(XL[i])) return 2;
    return XL[i] + 2;
  endfunction

  function automatic logic [31:0] pick(input int xlen);
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mask(xlen);
      3:       return 32'(1) << (xlen - 1);
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom & mask(xlen);
    endcase
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drive one start pulse (called #1 after an edge) and record what must come back
  task automatic issue(input int i, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes,
                       output int t, output int l);
    expT e;
    t = cyc;
    l = latency(i, f3, a, b);
    startS[i] = 1'b1;
    f3S[i] = f3;
    aS[i] = a;
    bS[i] = b;
    e.idx = i;
    e.res = expRes;
    e.doneCyc = t + l;
    sbq.push_back(e);
    bStart[i] = t + 1;
    bEnd[i] = t + l - 1;
    @(posedge clk); #1;
    startS[i] = 1'b0;
    f3S[i] = 3'($urandom);
    aS[i] = $urandom;
    bS[i] = $urandom;
  endtask

  task automatic randRun(input int i, input int n);
    logic [2:0]  f3;
    logic [31:0] a, b;
    int t, l;
    for (int k = 0; k < n; k++) begin
      f3 = 3'($urandom);
      a = pick(XL[i]);
      b = pick(XL[i]);
      issue(i, f3, a, b, refModel(XL[i], f3, a, b), t, l);
      cycles(l + int'($urandom_range(0, 2)));
    end
  endtask

  // Monitor: busy window, done timing, result value and result hold for every instance
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NDUT; i++) begin
        int j;
        j = -1;
        for (int k = 0; k < sbq.size(); k++)
          if (j < 0 && sbq[k].idx == i) j = k;
        check("busy", i, 32'(busyW[i]),
              (cyc >= bStart[i] && cyc <= bEnd[i]) ? 32'd1 : 32'd0);
        if (doneW[i]) begin
          if (j < 0) begin
            check("spurious_done", i, 32'(doneW[i]), 32'd0);
          end else begin
            check("result", i, resW[i], sbq[j].res);
            check("done_cycle", i, 32'(cyc), 32'(sbq[j].doneCyc));
            lastRes[i] = sbq[j].res;
            sbq.delete(j);
          end
        end else begin
          check("result_hold", i, resW[i], lastRes[i]);
          if (j >= 0 && cyc >= sbq[j].doneCyc) begin
            check("done_missing", i, 32'(doneW[i]), 32'd1);
            sbq.delete(j);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time %0t, expected $finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, l;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      startS[i] = 1'b0;
      flushS[i] = 1'b0;
      f3S[i] = 3'd0;
      aS[i] = 32'd0;
      bS[i] = 32'd0;
      bStart[i] = 1;
      bEnd[i] = 0;
      lastRes[i] = 32'd0;
    end
    cycles(3);
    for (int i = 0; i < NDUT; i++) begin
      check("reset_busy", i, 32'(busyW[i]), 32'd0);
      check("reset_done", i, 32'(doneW[i]), 32'd0);
      check("reset_result", i, resW[i], 32'd0);
    end
    rst_n = 1'b1;
    cycles(2);

    for (int k = 0; k < NDIR; k++) begin
      issue(0, DIRS[k].f3, DIRS[k].a, DIRS[k].b, DIRS[k].res, t, l);
      cycles(l);
    end

    // start pulsed mid-divide must be ignored
    issue(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, t, l);
    cycles(2);
    startS[0] = 1'b1;
    f3S[0] = 3'b000;
    aS[0] = 32'd3;
    bS[0] = 32'd5;
    cycles(1);
    startS[0] = 1'b0;
    cycles(l - 3);

    // start with flush in IDLE launches nothing
    startS[0] = 1'b1;
    flushS[0] = 1'b1;
    f3S[0] = 3'b000;
    aS[0] = 32'd7;
    bS[0] = 32'd9;
    cycles(1);
    startS[0] = 1'b0;
    flushS[0] = 1'b0;
    cycles(3);

    // flush in cycle T+5 of a divide, then start again right away
    issue(0, 3'b101, 32'd1000, 32'd3, 32'd333, t, l);
    cycles(4);
    flushS[0] = 1'b1;
    bEnd[0] = t + 5;
    sbq.delete(sbq.size() - 1);
    cycles(1);
    flushS[0] = 1'b0;
    issue(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, t, l);
    cycles(l);

    // asynchronous reset at T+10 of DIVU 100/7
    issue(0, 3'b101, 32'd100, 32'd7, 32'd14, t, l);
    cycles(9);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 0, 32'(busy0), 32'd0);
    check("rst_mid_done", 0, 32'(done0), 32'd0);
    check("rst_mid_result", 0, res0, 32'd0);
    sbq.delete(sbq.size() - 1);
    for (int i = 0; i < NDUT; i++) lastRes[i] = 32'd0;
    bStart[0] = 1;
    bEnd[0] = 0;
    #2;
    rst_n = 1'b1;
    cycles(1);
    issue(0, 3'b101, 32'd100, 32'd7, 32'd14, t, l);
    cycles(l);

    fork
      begin randRun(0, 30); end
      begin randRun(1, 60); end
      begin randRun(2, 60); end
    join

    cycles(5);
    check("pending", 0, 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
